// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcode encodings and flag register bit positions.
package cpu_pkg;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_ADC  = 4'd1;
   localparam logic [3:0] ALU_SUB  = 4'd2;
   localparam logic [3:0] ALU_SBC  = 4'd3;
   localparam logic [3:0] ALU_AND  = 4'd4;
   localparam logic [3:0] ALU_OR   = 4'd5;
   localparam logic [3:0] ALU_XOR  = 4'd6;
   localparam logic [3:0] ALU_NOT  = 4'd7;
   localparam logic [3:0] ALU_SHL  = 4'd8;
   localparam logic [3:0] ALU_SHR  = 4'd9;
   localparam logic [3:0] ALU_ROL  = 4'd10;
   localparam logic [3:0] ALU_ROR  = 4'd11;
   localparam logic [3:0] ALU_INC  = 4'd12;
   localparam logic [3:0] ALU_DEC  = 4'd13;
   localparam logic [3:0] ALU_PASS = 4'd14;
   localparam logic [3:0] ALU_CMP  = 4'd15;

   // Flag register layout is {C,Z,N,V}.
   localparam int FLAG_C = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: result plus C/Z/N/V for one opcode.
module alu_core
   import cpu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int OP_W  = 4
) (
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] lhs,
   input  logic [WIDTH-1:0] rhs,
   input  logic             c_in,
   output logic [WIDTH-1:0] result,
   output logic             c,
   output logic             z,
   output logic             n,
   output logic             v,
   output logic             write_result
);

   localparam int MSB = WIDTH - 1;

   logic             add_cin;
   logic             sub_bin;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] inc;
   logic [WIDTH-1:0] dec;
   logic             add_ovf;
   logic             sub_ovf;

   // One WIDTH+1 adder and subtractor; the top bit is the carry, or the borrow for subtracts.
   assign add_cin = (op == ALU_ADC) & c_in;
   assign sub_bin = (op == ALU_SBC) & ~c_in;
   assign sum     = {1'b0, lhs} + {1'b0, rhs} + {{WIDTH{1'b0}}, add_cin};
   assign diff    = {1'b0, lhs} - {1'b0, rhs} - {{WIDTH{1'b0}}, sub_bin};
   assign inc     = lhs + {{(WIDTH-1){1'b0}}, 1'b1};
   assign dec     = lhs - {{(WIDTH-1){1'b0}}, 1'b1};
   assign add_ovf = (lhs[MSB] == rhs[MSB]) && (sum[MSB] != lhs[MSB]);
   assign sub_ovf = (lhs[MSB] != rhs[MSB]) && (diff[MSB] != lhs[MSB]);

   always_comb begin
      result       = lhs;
      c            = c_in;
      v            = 1'b0;
      write_result = 1'b1;
      case (op)
         ALU_ADD, ALU_ADC: begin
            result = sum[MSB:0];
            c      = sum[WIDTH];
            v      = add_ovf;
         end
         ALU_SUB, ALU_SBC: begin
            result = diff[MSB:0];
            c      = ~diff[WIDTH];
            v      = sub_ovf;
         end
         ALU_AND:  result = lhs & rhs;
         ALU_OR:   result = lhs | rhs;
         ALU_XOR:  result = lhs ^ rhs;
         ALU_NOT:  result = ~lhs;
         ALU_SHL: begin
            result = {lhs[MSB-1:0], 1'b0};
            c      = lhs[MSB];
         end
         ALU_SHR: begin
            result = {1'b0, lhs[MSB:1]};
            c      = lhs[0];
         end
         ALU_ROL: begin
            result = {lhs[MSB-1:0], c_in};
            c      = lhs[MSB];
         end
         ALU_ROR: begin
            result = {c_in, lhs[MSB:1]};
            c      = lhs[0];
         end
         ALU_INC: begin
            result = inc;
            v      = ~lhs[MSB] & inc[MSB];
         end
         ALU_DEC: begin
            result = dec;
            v      = lhs[MSB] & ~dec[MSB];
         end
         ALU_PASS: result = lhs;
         ALU_CMP: begin
            result       = diff[MSB:0];
            c            = ~diff[WIDTH];
            v            = sub_ovf;
            write_result = 1'b0;
         end
         default: result = lhs;
      endcase
   end

   assign z = (result == '0);
   assign n = result[MSB];

endmodule

// File: rtl/alu_stage.sv
// Two-stage execute stage: operand latch, then result/flags registers with a tri-state MainBus driver.
module alu_stage
   import cpu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int OP_W  = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] LHSBus,
   input  logic [WIDTH-1:0] RHSBus,
   inout  wire  [WIDTH-1:0] MainBus,
   input  logic [OP_W-1:0]  op,
   input  logic             op_valid,
   input  logic             a_main_n,
   output logic             result_valid,
   output logic [3:0]       flags
);

   logic [WIDTH-1:0] lhs_q;
   logic [WIDTH-1:0] rhs_q;
   logic [OP_W-1:0]  op_q;
   logic             s1_valid;
   logic [WIDTH-1:0] result_q;

   logic [WIDTH-1:0] core_result;
   logic             core_c;
   logic             core_z;
   logic             core_n;
   logic             core_v;
   logic             core_write;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lhs_q    <= '0;
         rhs_q    <= '0;
         op_q     <= ALU_PASS;
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= op_valid;
         if (op_valid) begin
            lhs_q <= LHSBus;
            rhs_q <= RHSBus;
            op_q  <= op;
         end
      end
   end

   // Carry-in comes straight from the flags register, which the previous op has just updated.
   alu_core #(
      .WIDTH (WIDTH),
      .OP_W  (OP_W)
   ) u_core (
      .op           (op_q),
      .lhs          (lhs_q),
      .rhs          (rhs_q),
      .c_in         (flags[FLAG_C]),
      .result       (core_result),
      .c            (core_c),
      .z            (core_z),
      .n            (core_n),
      .v            (core_v),
      .write_result (core_write)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         result_q     <= '0;
         result_valid <= 1'b0;
         flags        <= '0;
      end else begin
         result_valid <= s1_valid;
         if (s1_valid) begin
            if (core_write) begin
               result_q <= core_result;
            end
            flags[FLAG_C] <= core_c;
            flags[FLAG_Z] <= core_z;
            flags[FLAG_N] <= core_n;
            flags[FLAG_V] <= core_v;
         end
      end
   end

   assign MainBus = (!a_main_n && reset_n) ? result_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_alu_stage.sv
// Self-checking bench for alu_stage: directed steps and random ops against an arithmetic reference model.
module tb_alu_stage;
   import cpu_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] lhs_bus;
   logic [7:0] rhs_bus;
   logic [3:0] op;
   logic       op_valid;
   logic       a_main_n;
   logic       result_valid;
   logic [3:0] flags;
   wire  [7:0] MainBus;

   int checks = 0;
   int errors = 0;

   int         m_res;
   logic [3:0] m_flags;
   logic       m_rv;
   logic       p_v;
   logic [3:0] p_op;
   logic [7:0] p_l;
   logic [7:0] p_r;

   always #5 clk = ~clk;

   // Background driver: whenever the DUT must release the bus, it reads back as 0x00.
   assign MainBus = (a_main_n || !reset_n) ? 8'h00 : 8'hzz;

   alu_stage #(.WIDTH(8), .OP_W(4)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .LHSBus       (lhs_bus),
      .RHSBus       (rhs_bus),
      .MainBus      (MainBus),
      .op           (op),
      .op_valid     (op_valid),
      .a_main_n     (a_main_n),
      .result_valid (result_valid),
      .flags        (flags)
   );

   function automatic void modelOp(input int o, input int l, input int r, input logic [3:0] fin,
                                   output int res, output logic [3:0] fout, output bit wr);
      int cin;
      int sl;
      int sr;
      int full;
      int sfull;
      bit c;
      bit v;
      cin   = int'(fin[3]);
      sl    = (l >= 128) ? l - 256 : l;
      sr    = (r >= 128) ? r - 256 : r;
      c     = fin[3];
      v     = 1'b0;
      wr    = 1'b1;
      full  = l;
      sfull = 0;
      case (o)
         0:  begin full = l + r;       sfull = sl + sr;       c = full > 255; v = sfull > 127 || sfull < -128; end
         1:  begin full = l + r + cin; sfull = sl + sr + cin; c = full > 255; v = sfull > 127 || sfull < -128; end
         2, 15: begin
            full = l - r; sfull = sl - sr; c = full >= 0; v = sfull > 127 || sfull < -128;
            wr = (o != 15);
         end
         3:  begin full = l - r - (1 - cin); sfull = sl - sr - (1 - cin); c = full >= 0; v = sfull > 127 || sfull < -128; end
         4:  full = l & r;
         5:  full = l | r;
         6:  full = l ^ r;
         7:  full = 255 - l;
         8:  begin full = l * 2;             c = l >= 128;    end
         9:  begin full = l / 2;             c = (l % 2) == 1; end
         10: begin full = l * 2 + cin;       c = l >= 128;    end
         11: begin full = l / 2 + cin * 128; c = (l % 2) == 1; end
         12: begin full = l + 1; sfull = sl + 1; v = sfull > 127; end
         13: begin full = l - 1; sfull = sl - 1; v = sfull < -128; end
         default: full = l;
      endcase
      res  = full & 255;
      fout = {c, res == 0, res >= 128, v};
   endfunction

   task automatic resetModel();
      m_res   = 0;
      m_flags = 4'h0;
      m_rv    = 1'b0;
      p_v     = 1'b0;
      p_op    = ALU_PASS;
      p_l     = 8'h00;
      p_r     = 8'h00;
   endtask

   task automatic checkEq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      logic [7:0] bus_exp;
      bus_exp = (!a_main_n && reset_n) ? m_res[7:0] : 8'h00;
      checkEq({tag, ".valid"}, {7'b0, result_valid}, {7'b0, m_rv});
      checkEq({tag, ".flags"}, {4'b0, flags}, {4'b0, m_flags});
      checkEq({tag, ".bus"}, MainBus, bus_exp);
   endtask

   // Drives one cycle of inputs, advances the reference pipeline, then checks on the falling edge.
   task automatic applyStimulus(input logic v, input logic [3:0] o, input logic [7:0] l,
                                input logic [7:0] r, input logic amn, input string tag);
      int         res;
      logic [3:0] fl;
      bit         wr;
      op_valid = v;
      op       = o;
      lhs_bus  = l;
      rhs_bus  = r;
      a_main_n = amn;
      @(posedge clk);
      @(negedge clk);
      if (p_v) begin
         modelOp(int'(p_op), int'(p_l), int'(p_r), m_flags, res, fl, wr);
         if (wr) m_res = res;
         m_flags = fl;
      end
      m_rv = p_v;
      p_v  = v;
      p_op = o;
      p_l  = l;
      p_r  = r;
      checkOutput(tag);
   endtask

   initial begin
      reset_n  = 1'b0;
      op_valid = 1'b0;
      op       = 4'h0;
      lhs_bus  = 8'h00;
      rhs_bus  = 8'h00;
      a_main_n = 1'b0;
      resetModel();
      repeat (2) @(negedge clk);
      checkOutput("reset");
      reset_n = 1'b1;

      applyStimulus(1'b1, ALU_ADD, 8'hFF, 8'h01, 1'b0, "add");
      applyStimulus(1'b1, ALU_ADC, 8'h00, 8'h00, 1'b0, "adc");
      checkEq("add_ff01.res", MainBus, 8'h00);
      checkEq("add_ff01.flags", {4'b0, flags}, 8'h0C);
      applyStimulus(1'b0, ALU_ADD, 8'h00, 8'h00, 1'b0, "adc_done");
      checkEq("adc_chain.res", MainBus, 8'h01);
      checkEq("adc_chain.valid", {7'b0, result_valid}, 8'h01);
      checkEq("adc_chain.flags", {4'b0, flags}, 8'h00);
      applyStimulus(1'b0, ALU_ADD, 8'h00, 8'h00, 1'b0, "idle0");

      applyStimulus(1'b1, ALU_SUB, 8'h50, 8'h70, 1'b0, "sub0");
      applyStimulus(1'b1, ALU_SUB, 8'h80, 8'h01, 1'b0, "sub1");
      checkEq("sub_50_70.res", MainBus, 8'hE0);
      checkEq("sub_50_70.flags", {4'b0, flags}, 8'h02);
      applyStimulus(1'b0, ALU_ADD, 8'h00, 8'h00, 1'b0, "sub_done");
      checkEq("sub_80_01.res", MainBus, 8'h7F);
      checkEq("sub_80_01.flags", {4'b0, flags}, 8'h09);

      applyStimulus(1'b1, ALU_PASS, 8'hAA, 8'h00, 1'b0, "pass");
      applyStimulus(1'b1, ALU_CMP, 8'h33, 8'h33, 1'b0, "cmp");
      applyStimulus(1'b0, ALU_ADD, 8'h00, 8'h00, 1'b0, "cmp_done");
      checkEq("cmp.res_held", MainBus, 8'hAA);
      checkEq("cmp.flags", {4'b0, flags}, 8'h0C);

      applyStimulus(1'b1, ALU_ADD, 8'h00, 8'h00, 1'b0, "clr_c");
      applyStimulus(1'b1, ALU_ROL, 8'h81, 8'h00, 1'b0, "rol0");
      applyStimulus(1'b1, ALU_ROL, 8'h02, 8'h00, 1'b0, "rol1");
      checkEq("rol_81.res", MainBus, 8'h02);
      checkEq("rol_81.flags", {4'b0, flags}, 8'h08);
      applyStimulus(1'b0, ALU_ADD, 8'h00, 8'h00, 1'b0, "rol_done");
      checkEq("rol_02.res", MainBus, 8'h05);
      checkEq("rol_02.flags", {4'b0, flags}, 8'h00);

      applyStimulus(1'b1, ALU_SUB, 8'h05, 8'h03, 1'b0, "set_c");
      applyStimulus(1'b1, ALU_AND, 8'hF0, 8'h0F, 1'b1, "and");
      applyStimulus(1'b0, ALU_ADD, 8'h00, 8'h00, 1'b1, "and_wait");
      applyStimulus(1'b0, ALU_ADD, 8'h00, 8'h00, 1'b1, "and_done");
      checkEq("and.flags", {4'b0, flags}, 8'h0C);
      checkEq("and.bus_released", MainBus, 8'h00);
      applyStimulus(1'b0, ALU_ADD, 8'h00, 8'h00, 1'b0, "and_read");

      for (int i = 0; i < 300; i++) begin
         applyStimulus(($urandom % 4) != 0, 4'($urandom % 16), 8'($urandom % 256),
                       8'($urandom % 256), 1'($urandom % 2), "rand");
      end

      applyStimulus(1'b1, ALU_ADD, 8'h12, 8'h34, 1'b0, "pre_rst0");
      applyStimulus(1'b1, ALU_XOR, 8'h5A, 8'hFF, 1'b0, "pre_rst1");
      op_valid = 1'b1;
      op       = ALU_SUB;
      lhs_bus  = 8'h10;
      rhs_bus  = 8'h20;
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1 resetModel();
      checkOutput("rst_mid");
      @(negedge clk);
      reset_n = 1'b1;
      applyStimulus(1'b0, ALU_ADD, 8'h00, 8'h00, 1'b0, "post_rst0");
      applyStimulus(1'b0, ALU_ADD, 8'h00, 8'h00, 1'b0, "post_rst1");
      applyStimulus(1'b1, ALU_INC, 8'h7F, 8'h00, 1'b0, "inc");
      applyStimulus(1'b1, ALU_DEC, 8'h80, 8'h00, 1'b0, "dec");
      applyStimulus(1'b0, ALU_ADD, 8'h00, 8'h00, 1'b0, "dec_done");
      applyStimulus(1'b0, ALU_ADD, 8'h00, 8'h00, 1'b0, "final");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
